// File: rtl/core_pkg.sv
// Shared core definitions: memory opcodes and LSU state encoding.
// Imported by the load/store unit and its alignment helper.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int MEMOP_W = 3;

  localparam logic [MEMOP_W-1:0] MEM_B  = 3'b000;
  localparam logic [MEMOP_W-1:0] MEM_H  = 3'b001;
  localparam logic [MEMOP_W-1:0] MEM_W  = 3'b010;
  localparam logic [MEMOP_W-1:0] MEM_BU = 3'b100;
  localparam logic [MEMOP_W-1:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper: store strobe/replication and load shift/extension.
// Purely combinational; shared by the store and load paths.
module lsu_align
  import core_pkg::*;
(
  input  logic [MEMOP_W-1:0] op,
  input  logic [1:0]         off,
  input  logic [XLEN-1:0]    wdata,
  input  logic [XLEN-1:0]    rdata,
  output logic [3:0]         wstrb,
  output logic [XLEN-1:0]    wlane,
  output logic [XLEN-1:0]    rext
);

  logic [XLEN-1:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    wstrb = 4'hF;
    wlane = wdata;
    unique case (op[1:0])
      2'b00: begin
        wstrb = 4'b0001 << off;
        wlane = {4{wdata[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << off;
        wlane = {2{wdata[15:0]}};
      end
      default: begin
        wstrb = 4'hF;
        wlane = wdata;
      end
    endcase
  end

  always_comb begin
    rext = sh;
    unique case (op)
      MEM_B:   rext = {{24{sh[7]}}, sh[7:0]};
      MEM_H:   rext = {{16{sh[15]}}, sh[15:0]};
      MEM_BU:  rext = {24'b0, sh[7:0]};
      MEM_HU:  rext = {16'b0, sh[15:0]};
      default: rext = sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: traps bad accesses, drives a
// valid/ready data bus and returns extended load data.
module lsu
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               rst_b,
  input  logic               lsu_valid,
  input  logic               lsu_read,
  input  logic               lsu_write,
  input  logic [MEMOP_W-1:0] lsu_opcode,
  input  logic [XLEN-1:0]    lsu_addr,
  input  logic [XLEN-1:0]    lsu_wdata,
  output logic               lsu_stall,
  output logic               lsu_done,
  output logic               lsu_fault,
  output logic [XLEN-1:0]    lsu_rdata,
  output logic               bus_req_valid,
  input  logic               bus_req_ready,
  output logic               bus_req_write,
  output logic [XLEN-1:0]    bus_req_addr,
  output logic [XLEN-1:0]    bus_req_wdata,
  output logic [3:0]         bus_req_wstrb,
  input  logic               bus_rsp_valid,
  input  logic [XLEN-1:0]    bus_rsp_rdata
);

  lsu_state_e state, state_n;

  logic [MEMOP_W-1:0] op_q;
  logic [1:0]         off_q;
  logic               write_q;
  logic               fault_q;
  logic [XLEN-1:0]    addr_q;
  logic [XLEN-1:0]    wdata_q;
  logic [XLEN-1:0]    rdata_q;
  logic [3:0]         wstrb_q;

  logic               req;
  logic               accept;
  logic               legal;
  logic               misal;
  logic               bad;
  logic [MEMOP_W-1:0] a_op;
  logic [1:0]         a_off;
  logic [3:0]         a_strb;
  logic [XLEN-1:0]    a_wlane;
  logic [XLEN-1:0]    a_rext;

  assign req    = lsu_valid & (lsu_read | lsu_write);
  assign accept = (state == S_IDLE) & req;

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      lsu_write: legal = lsu_opcode inside {MEM_B, MEM_H, MEM_W};
      default:   legal = lsu_opcode inside
                   {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};
    endcase
  end

  assign misal = ((lsu_opcode[1:0] == 2'b01) & lsu_addr[0])
               | ((lsu_opcode[1:0] == 2'b10) & (|lsu_addr[1:0]));
  assign bad   = ~legal | misal;

  // One aligner serves the store path at accept and the load path in RSP.
  assign a_op  = (state == S_IDLE) ? lsu_opcode    : op_q;
  assign a_off = (state == S_IDLE) ? lsu_addr[1:0] : off_q;

  lsu_align u_align (
    .op    (a_op),
    .off   (a_off),
    .wdata (lsu_wdata),
    .rdata (bus_rsp_rdata),
    .wstrb (a_strb),
    .wlane (a_wlane),
    .rext  (a_rext)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept) state_n = bad ? S_DONE : S_REQ;
      S_REQ:  if (bus_req_ready) state_n = S_RSP;
      S_RSP:  if (bus_rsp_valid) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_q    <= '0;
      off_q   <= '0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      op_q    <= lsu_opcode;
      off_q   <= lsu_addr[1:0];
      write_q <= lsu_write;
      fault_q <= bad;
      addr_q  <= {lsu_addr[XLEN-1:2], 2'b00};
      wdata_q <= lsu_write ? a_wlane : '0;
      wstrb_q <= lsu_write ? a_strb : 4'b0;
      rdata_q <= '0;
    end else if ((state == S_RSP) & bus_rsp_valid & ~write_q) begin
      rdata_q <= a_rext;
    end
  end

  assign bus_req_valid = (state == S_REQ);
  assign bus_req_write = write_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign bus_req_wstrb = wstrb_q;

  assign lsu_done  = (state == S_DONE);
  assign lsu_fault = lsu_done & fault_q;
  assign lsu_rdata = rdata_q;
  assign lsu_stall = rst_b & req & ~lsu_done;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu against a lane/extension reference model.
// Includes directed cases for alignment, faults, waits and reset.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        lsu_valid;
  logic        lsu_read;
  logic        lsu_write;
  logic [2:0]  lsu_opcode;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_stall;
  logic        lsu_done;
  logic        lsu_fault;
  logic [31:0] lsu_rdata;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_write;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .lsu_valid     (lsu_valid),
    .lsu_read      (lsu_read),
    .lsu_write     (lsu_write),
    .lsu_opcode    (lsu_opcode),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_stall     (lsu_stall),
    .lsu_done      (lsu_done),
    .lsu_fault     (lsu_fault),
    .lsu_rdata     (lsu_rdata),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_write (bus_req_write),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_wstrb (bus_req_wstrb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_fault(logic wr, logic [2:0] op,
                                 logic [31:0] a);
    bit legal, mis;
    if (wr) legal = (op <= 3'd2);
    else    legal = (op <= 3'd2) || (op == 3'd4) || (op == 3'd5);
    mis = ((op == 3'd1 || op == 3'd5) && a[0])
       || (op == 3'd2 && (a % 4) != 0);
    return !legal || mis;
  endfunction

  function automatic logic [3:0] m_strb(logic [2:0] op, logic [31:0] a);
    int off = int'(a % 4);
    if (op == 3'd0) return 4'(1 << off);
    if (op == 3'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] op,
                                          logic [31:0] d);
    if (op == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (op == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] op, logic [31:0] a,
                                         logic [31:0] r);
    logic [31:0] v;
    longint s;
    v = r >> (8 * (a % 4));
    case (op)
      3'd0: begin
        s = longint'(v & 32'hFF);
        if (s >= 128) s = s - 256;
        return 32'(s);
      end
      3'd1: begin
        s = longint'(v & 32'hFFFF);
        if (s >= 32768) s = s - 65536;
        return 32'(s);
      end
      3'd4:    return v & 32'hFF;
      3'd5:    return v & 32'hFFFF;
      default: return v;
    endcase
  endfunction

  task automatic do_op(input logic rd, input logic wr,
                       input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdat,
                       input int rdy_dly, input int rsp_dly,
                       input bit scr);
    bit flt, ph_rsp, hs, sent, fin;
    int rq_wait, rs_wait;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0] e_strb;
    flt    = m_fault(wr, op, addr);
    e_addr = addr & ~32'h3;
    e_strb = wr ? m_strb(op, addr) : 4'h0;
    e_wd   = m_wdata(op, wd);
    e_rd   = wr ? 32'h0 : m_load(op, addr, rdat);
    @(posedge clk);
    #1;
    lsu_valid  = 1'b1;
    lsu_read   = rd;
    lsu_write  = wr;
    lsu_opcode = op;
    lsu_addr   = addr;
    lsu_wdata  = wd;
    fin = 0; ph_rsp = 0; hs = 0; sent = 0;
    rq_wait = 0; rs_wait = 0;
    for (int c = 0; c < 80 && !fin; c++) begin
      @(negedge clk);
      if (hs) begin
        ph_rsp = 1;
        hs = 0;
      end
      bus_rsp_valid = 1'b0;
      bus_req_ready = 1'b0;
      if (lsu_done) begin
        fin = 1;
        chk("fault", 32'(lsu_fault), 32'(flt));
        if (!flt) chk("rdata", lsu_rdata, e_rd);
        if (flt || (rdy_dly == 0 && rsp_dly == 0))
          chk("latency", 32'(c), flt ? 32'd1 : 32'd3);
        chk("stall_at_done", 32'(lsu_stall), 32'd0);
        chk("bus_used", 32'(ph_rsp), 32'(!flt));
      end else begin
        chk("stall", 32'(lsu_stall), 32'd1);
        if (c == 1 && scr) begin
          lsu_opcode = 3'($urandom);
          lsu_addr   = $urandom;
          lsu_wdata  = $urandom;
        end
        if (bus_req_valid) begin
          chk("req_phase", 32'(flt || ph_rsp), 32'd0);
          chk("req_write", 32'(bus_req_write), 32'(wr));
          chk("req_addr", bus_req_addr, e_addr);
          chk("req_wstrb", 32'(bus_req_wstrb), 32'(e_strb));
          if (wr) chk("req_wdata", bus_req_wdata, e_wd);
          if (rq_wait >= rdy_dly) begin
            bus_req_ready = 1'b1;
            hs = 1;
          end else begin
            rq_wait++;
            if ($urandom_range(0, 1) == 1) begin
              bus_rsp_valid = 1'b1;
              bus_rsp_rdata = $urandom;
            end
          end
        end else if (ph_rsp && !sent) begin
          if (rs_wait >= rsp_dly) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_rdata = rdat;
            sent = 1;
          end else begin
            rs_wait++;
          end
        end
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    lsu_valid = 1'b0;
    lsu_read  = 1'b0;
    lsu_write = 1'b0;
    @(negedge clk);
    chk("done_once", 32'(lsu_done), 32'd0);
    chk("idle_req", 32'(bus_req_valid), 32'd0);
  endtask

  initial begin
    logic [2:0] op;
    logic rd, wr;
    int k;
    rst_b = 1'b0;
    lsu_valid = 1'b1;
    lsu_read = 1'b1;
    lsu_write = 1'b0;
    lsu_opcode = 3'd2;
    lsu_addr = 32'h0;
    lsu_wdata = 32'h0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_fault", 32'(lsu_fault), 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_req", 32'(bus_req_valid), 32'd0);
    chk("rst_addr", bus_req_addr, 32'd0);
    chk("rst_wstrb", 32'(bus_req_wstrb), 32'd0);
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    lsu_valid = 1'b0;
    lsu_read = 1'b0;
    rst_b = 1'b1;

    do_op(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    do_op(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0);
    do_op(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0);
    do_op(1, 0, 3'd1, 32'h102, 32'h0, 32'h80FF0000, 0, 0, 0);
    do_op(0, 1, 3'd0, 32'h201, 32'hA5, 32'h0, 0, 0, 0);
    do_op(0, 1, 3'd1, 32'h202, 32'h1234, 32'h0, 0, 0, 0);
    do_op(0, 1, 3'd2, 32'h302, 32'h55, 32'h0, 0, 0, 0);
    do_op(1, 0, 3'd3, 32'h300, 32'h0, 32'h0, 0, 0, 0);
    do_op(0, 1, 3'd4, 32'h300, 32'h0, 32'h0, 0, 0, 0);
    do_op(1, 1, 3'd2, 32'h108, 32'hCAFEF00D, 32'h1, 0, 0, 0);
    do_op(1, 0, 3'd2, 32'h104, 32'h0, 32'h12345678, 3, 2, 1);

    @(negedge clk);
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    chk("spur_done", 32'(lsu_done), 32'd0);
    chk("spur_req", 32'(bus_req_valid), 32'd0);
    do_op(1, 0, 3'd5, 32'h10E, 32'h0, 32'h8001_7777, 0, 1, 0);

    @(posedge clk);
    #1;
    lsu_valid = 1'b1;
    lsu_read = 1'b1;
    lsu_opcode = 3'd2;
    lsu_addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_req", 32'(bus_req_valid), 32'd1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("rst_mid_req", 32'(bus_req_valid), 32'd0);
    chk("rst_mid_done", 32'(lsu_done), 32'd0);
    chk("rst_mid_stall", 32'(lsu_stall), 32'd0);
    lsu_valid = 1'b0;
    lsu_read = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    do_op(1, 0, 3'd2, 32'h400, 32'h0, 32'h0BADF00D, 0, 0, 0);

    for (k = 0; k < 250; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    begin rd = 1; wr = 0; end
        2:       begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 1; end
      endcase
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: op = 3'd0;
          1: op = 3'd1;
          2: op = 3'd2;
          3: op = 3'd4;
          default: op = 3'd5;
        endcase
      end else begin
        op = 3'($urandom);
      end
      do_op(rd, wr, op, $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
